evm_ballot_unit: RTL and testbench

// Voter-side controller driving the EVM control unit's input protocol and reading back the final tally.
// Per voter: arms the EVM, debounces the voter's three buttons and issues exactly one vote pulse.
// At close of poll: ends the session, sequences the readout, captures tallies and winner, and audits them against local shadow counts.

---
 rtl/evm_ballot_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_evm_ballot_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_ballot_unit.sv
// Voter-side controller for the EVM control unit: admits one voter at a time,
// debounces the three candidate buttons, issues a single vote pulse, then at
// close of poll sequences the tally readout and audits it against shadow counts.
module evm_ballot_unit #(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_voter,
    input  logic             close_session,
    input  logic [2:0]       button,
    input  logic             voting_in_progress,
    input  logic             voting_done,
    input  logic             invalid_results,
    input  logic [1:0]       candidate_name,
    input  logic [WIDTH-1:0] results,
    output logic             candidate_ready,
    output logic             vote_candidate_1,
    output logic             vote_candidate_2,
    output logic             vote_candidate_3,
    output logic             voting_session_done,
    output logic [1:0]       display_results,
    output logic             display_winner,
    output logic             vote_recorded,
    output logic             busy,
    output logic [WIDTH-1:0] tally_1,
    output logic [WIDTH-1:0] tally_2,
    output logic [WIDTH-1:0] tally_3,
    output logic [1:0]       winner,
    output logic             tie,
    output logic             audit_mismatch,
    output logic             tally_valid,
    output logic             fault
);

    localparam int unsigned DBW = $clog2(DEBOUNCE + 1);
    localparam int unsigned TW  = $clog2(ACK_TIMEOUT + DEBOUNCE + 1);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE);
    localparam logic [TW-1:0]  TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]  RL_LAST = TW'(DEBOUNCE - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ARM      = 4'd1;
    localparam logic [3:0] WAIT_VIP = 4'd2;
    localparam logic [3:0] WAIT_BTN = 4'd3;
    localparam logic [3:0] VOTE     = 4'd4;
    localparam logic [3:0] WAIT_ACK = 4'd5;
    localparam logic [3:0] RELEASE  = 4'd6;
    localparam logic [3:0] CLOSE    = 4'd7;
    localparam logic [3:0] READ     = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;
    localparam logic [3:0] FAULT    = 4'd10;

    logic [3:0]                 state_q, state_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [2:0][DBW-1:0]        db_q, db_d;
    logic                       lock_q, lock_d;
    logic [2:0]                 sel_q, sel_d;
    logic                       close_pending_q, close_pending_d;
    logic [2:0]                 rd_cnt_q, rd_cnt_d;
    logic [2:0][WIDTH-1:0]      shadow_q, shadow_d;
    logic [2:0][WIDTH-1:0]      tally_q, tally_d;
    logic [1:0]                 winner_q, winner_d;
    logic                       tie_q, tie_d;
    logic                       vote_recorded_d;
    logic [2:0]                 stable;
    logic                       multi;

    assign multi = (button[0] & button[1]) | (button[0] & button[2]) | (button[1] & button[2]);

    assign tally_1 = tally_q[0];
    assign tally_2 = tally_q[1];
    assign tally_3 = tally_q[2];
    assign winner  = winner_q;
    assign tie     = tie_q;

    // Next-state, debounce, shadow-count and readout-capture logic
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q + TW'(1);
        db_d            = db_q;
        lock_d          = lock_q;
        sel_d           = sel_q;
        close_pending_d = close_pending_q | close_session;
        rd_cnt_d        = rd_cnt_q;
        shadow_d        = shadow_q;
        tally_d         = tally_q;
        winner_d        = winner_q;
        tie_d           = tie_q;
        vote_recorded_d = 1'b0;
        stable          = 3'b000;
        for (int i = 0; i < 3; i++) begin
            stable[i] = (db_q[i] == DB_MAX);
        end

        case (state_q)
            IDLE: begin
                // A close request beats a simultaneous voter admission
                if (close_pending_q || close_session) state_d = CLOSE;
                else if (enable_voter)                state_d = ARM;
            end
            ARM: state_d = WAIT_VIP;
            WAIT_VIP: begin
                if (voting_in_progress)      state_d = WAIT_BTN;
                else if (timer_q == TO_LAST) state_d = FAULT;
            end
            WAIT_BTN: begin
                // Multiple presses lock out voting until every button is released
                if (multi || (lock_q && button != 3'b000)) begin
                    lock_d = 1'b1;
                    db_d   = '0;
                end else begin
                    lock_d = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        if (!button[i])            db_d[i] = '0;
                        else if (db_q[i] != DB_MAX) db_d[i] = db_q[i] + DBW'(1);
                    end
                    if ((button & stable) != 3'b000) begin
                        sel_d   = button;
                        state_d = VOTE;
                    end
                end
            end
            VOTE: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!voting_in_progress) begin
                    vote_recorded_d = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        if (sel_q[i]) shadow_d[i] = shadow_q[i] + WIDTH'(1);
                    end
                    state_d = RELEASE;
                end else if (timer_q == TO_LAST) begin
                    state_d = FAULT;
                end
            end
            RELEASE: begin
                // Timer counts consecutive all-released cycles here
                if (button != 3'b000)        timer_d = '0;
                else if (timer_q == RL_LAST) state_d = IDLE;
            end
            CLOSE: begin
                // Waiting on voting_done is an EVM response, so it is timed too
                if (voting_done) begin
                    state_d         = READ;
                    close_pending_d = close_session;
                    rd_cnt_d        = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d = FAULT;
                end
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + 3'd1;
                if (rd_cnt_q[0]) begin
                    case (rd_cnt_q[2:1])
                        2'd0:    tally_d[0] = results;
                        2'd1:    tally_d[1] = results;
                        2'd2:    tally_d[2] = results;
                        default: begin
                            winner_d = candidate_name;
                            tie_d    = invalid_results;
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            DONE:    ;
            FAULT:   ;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) timer_d = '0;
        if (state_d != WAIT_BTN) begin
            db_d   = '0;
            lock_d = 1'b0;
        end
    end

    // State and registered outputs, all decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            timer_q             <= '0;
            db_q                <= '0;
            lock_q              <= 1'b0;
            sel_q               <= 3'b000;
            close_pending_q     <= 1'b0;
            rd_cnt_q            <= '0;
            shadow_q            <= '0;
            tally_q             <= '0;
            winner_q            <= 2'b00;
            tie_q               <= 1'b0;
            candidate_ready     <= 1'b0;
            vote_candidate_1    <= 1'b0;
            vote_candidate_2    <= 1'b0;
            vote_candidate_3    <= 1'b0;
            voting_session_done <= 1'b0;
            display_results     <= 2'b00;
            display_winner      <= 1'b0;
            vote_recorded       <= 1'b0;
            busy                <= 1'b0;
            audit_mismatch      <= 1'b0;
            tally_valid         <= 1'b0;
            fault               <= 1'b0;
        end else begin
            state_q             <= state_d;
            timer_q             <= timer_d;
            db_q                <= db_d;
            lock_q              <= lock_d;
            sel_q               <= sel_d;
            close_pending_q     <= close_pending_d;
            rd_cnt_q            <= rd_cnt_d;
            shadow_q            <= shadow_d;
            tally_q             <= tally_d;
            winner_q            <= winner_d;
            tie_q               <= tie_d;
            candidate_ready     <= (state_d == ARM);
            vote_candidate_1    <= (state_d == VOTE) && sel_d[0];
            vote_candidate_2    <= (state_d == VOTE) && sel_d[1];
            vote_candidate_3    <= (state_d == VOTE) && sel_d[2];
            voting_session_done <= (state_d == CLOSE);
            display_results     <= (state_d == READ && rd_cnt_d[2:1] != 2'd3) ?
                                   rd_cnt_d[2:1] : 2'b00;
            display_winner      <= (state_d == READ) && (rd_cnt_d[2:1] == 2'd3);
            vote_recorded       <= vote_recorded_d;
            busy                <= (state_d == WAIT_VIP) || (state_d == WAIT_BTN) ||
                                   (state_d == VOTE) || (state_d == WAIT_ACK) ||
                                   (state_d == RELEASE);
            audit_mismatch      <= (state_d == DONE) && !tie_d && (tally_d != shadow_d);
            tally_valid         <= (state_d == DONE);
            fault               <= (state_d == FAULT);
        end
    end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Bench for evm_ballot_unit: a small behavioural EVM answers the control
// protocol; vote scenarios come from a table, readout and timeout corners
// are hand-written sequences.
module tb_evm_ballot_unit;

    localparam int W = 7;

    logic clk = 1'b0;
    logic rst, enable_voter, close_session;
    logic [2:0] button;
    logic voting_in_progress, voting_done, invalid_results;
    logic [1:0] candidate_name;
    logic [W-1:0] results;
    logic candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3;
    logic voting_session_done, display_winner, vote_recorded, busy;
    logic [1:0] display_results, winner;
    logic [W-1:0] tally_1, tally_2, tally_3;
    logic tie, audit_mismatch, tally_valid, fault;

    always #5 clk = ~clk;

    evm_ballot_unit #(.WIDTH(W), .DEBOUNCE(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .enable_voter(enable_voter), .close_session(close_session),
        .button(button), .voting_in_progress(voting_in_progress), .voting_done(voting_done),
        .invalid_results(invalid_results), .candidate_name(candidate_name), .results(results),
        .candidate_ready(candidate_ready), .vote_candidate_1(vote_candidate_1),
        .vote_candidate_2(vote_candidate_2), .vote_candidate_3(vote_candidate_3),
        .voting_session_done(voting_session_done), .display_results(display_results),
        .display_winner(display_winner), .vote_recorded(vote_recorded), .busy(busy),
        .tally_1(tally_1), .tally_2(tally_2), .tally_3(tally_3), .winner(winner), .tie(tie),
        .audit_mismatch(audit_mismatch), .tally_valid(tally_valid), .fault(fault)
    );

    // Behavioural EVM
    logic mute, corrupt;
    logic [2:0][W-1:0] ecnt;
    logic [1:0] pend;
    logic [1:0] ewin;

    always @(posedge clk) begin
        if (rst) begin
            voting_in_progress <= 1'b0;
            voting_done        <= 1'b0;
            ecnt               <= '0;
            pend               <= 2'd0;
        end else begin
            if (candidate_ready && !mute) voting_in_progress <= 1'b1;
            if (vote_candidate_1 | vote_candidate_2 | vote_candidate_3) begin
                if (vote_candidate_1) ecnt[0] <= ecnt[0] + 1'b1;
                if (vote_candidate_2) ecnt[1] <= ecnt[1] + 1'b1;
                if (vote_candidate_3) ecnt[2] <= ecnt[2] + 1'b1;
                pend <= 2'd2;
            end else if (pend != 2'd0) begin
                pend <= pend - 2'd1;
                if (pend == 2'd1) voting_in_progress <= 1'b0;
            end
            if (voting_session_done) voting_done <= 1'b1;
        end
    end

    always_comb begin
        ewin = 2'b00;
        if (ecnt[0] > ecnt[1] && ecnt[0] > ecnt[2])      ewin = 2'b01;
        else if (ecnt[1] > ecnt[0] && ecnt[1] > ecnt[2]) ewin = 2'b10;
        else if (ecnt[2] > ecnt[0] && ecnt[2] > ecnt[1]) ewin = 2'b11;
        invalid_results = (ewin == 2'b00);
        candidate_name  = ewin;
        results         = '0;
        if (!invalid_results && display_results != 2'b11) begin
            results = ecnt[display_results];
            if (corrupt && display_results == 2'b01) results = results + 1'b1;
        end
    end

    // Pulse monitor
    int cr_cnt, vc_cnt, vr_cnt, early_cnt, seg_idx;
    logic [2:0] vc_mask;

    always @(negedge clk) begin
        if (candidate_ready) cr_cnt++;
        if (vote_candidate_1 | vote_candidate_2 | vote_candidate_3) begin
            vc_cnt++;
            vc_mask = vc_mask | {vote_candidate_3, vote_candidate_2, vote_candidate_1};
            if (seg_idx < 4) early_cnt++;
        end
        if (vote_recorded) vr_cnt++;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return busy;
            1:       return tally_valid;
            default: return voting_session_done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic level, input int max, input string name);
        int k = 0;
        while (get_sig(sel) !== level && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(get_sig(sel)), 64'(level));
    endtask

    task automatic clear_mon();
        cr_cnt = 0; vc_cnt = 0; vr_cnt = 0; early_cnt = 0; vc_mask = 3'b000; seg_idx = 5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_enable();
        enable_voter = 1'b1;
        @(negedge clk);
        enable_voter = 1'b0;
    endtask

    task automatic do_vote(input logic [2:0] b);
        pulse_enable();
        wait_for(0, 1'b1, 10, "vote_busy_rise");
        @(negedge clk);
        button = b;
        repeat (6) @(negedge clk);
        button = 3'b000;
        wait_for(0, 1'b0, 40, "vote_busy_fall");
    endtask

    task automatic close_poll();
        close_session = 1'b1;
        @(negedge clk);
        close_session = 1'b0;
        wait_for(1, 1'b1, 40, "tally_valid_rise");
    endtask

    typedef struct packed {
        logic [4:0][2:0] btn;
        logic [4:0][3:0] len;
        logic [2:0]      exp;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] b0, input int l0, input logic [2:0] b1,
                                input int l1, input logic [2:0] b2, input int l2,
                                input logic [2:0] b3, input int l3, input logic [2:0] b4,
                                input int l4, input logic [2:0] e);
        vec_t v;
        v.btn = {b4, b3, b2, b1, b0};
        v.len = {4'(l4), 4'(l3), 4'(l2), 4'(l1), 4'(l0)};
        v.exp = e;
        return v;
    endfunction

    vec_t vecs [5];

    initial begin
        rst = 1'b1; enable_voter = 1'b0; close_session = 1'b0; button = 3'b000;
        mute = 1'b0; corrupt = 1'b0;
        clear_mon();

        vecs[0] = mk(3'b000, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 3'b010, 6, 3'b010);
        vecs[1] = mk(3'b001, 3, 3'b000, 1, 3'b001, 2, 3'b000, 1, 3'b001, 6, 3'b001);
        vecs[2] = mk(3'b000, 0, 3'b000, 0, 3'b101, 6, 3'b000, 2, 3'b100, 6, 3'b100);
        vecs[3] = mk(3'b000, 0, 3'b000, 0, 3'b111, 5, 3'b000, 1, 3'b001, 6, 3'b001);
        vecs[4] = mk(3'b000, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 3'b100, 6, 3'b100);

        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3,
                   voting_session_done, display_results, display_winner, vote_recorded, busy,
                   tally_1, tally_2, tally_3, winner, tie, audit_mismatch, tally_valid, fault}),
              64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven voter sessions
        for (int i = 0; i < 5; i++) begin
            clear_mon();
            pulse_enable();
            wait_for(0, 1'b1, 10, "vec_busy_rise");
            @(negedge clk);
            for (int s = 0; s < 5; s++) begin
                seg_idx = s;
                button  = vecs[i].btn[s];
                repeat (int'(vecs[i].len[s])) @(negedge clk);
            end
            seg_idx = 5;
            button  = 3'b000;
            wait_for(0, 1'b0, 40, "vec_busy_fall");
            check($sformatf("vec%0d_vote_mask", i), 64'(vc_mask), 64'(vecs[i].exp));
            check($sformatf("vec%0d_vote_pulses", i), 64'(vc_cnt), 64'd1);
            check($sformatf("vec%0d_recorded", i), 64'(vr_cnt), 64'd1);
            check($sformatf("vec%0d_cand_ready", i), 64'(cr_cnt), 64'd1);
            check($sformatf("vec%0d_early", i), 64'(early_cnt), 64'd0);
        end

        // Votes 3/1/2 -> candidate 1 wins
        do_reset();
        repeat (3) do_vote(3'b001);
        do_vote(3'b010);
        repeat (2) do_vote(3'b100);
        close_poll();
        check("t312_tallies", 64'({tally_1, tally_2, tally_3}), 64'({7'd3, 7'd1, 7'd2}));
        check("t312_winner", 64'(winner), 64'd1);
        check("t312_tie", 64'(tie), 64'd0);
        check("t312_audit", 64'(audit_mismatch), 64'd0);
        check("t312_drives", 64'({voting_session_done, display_winner, display_results}), 64'd0);

        // Votes 2/2/0 -> tie, EVM reports zeros
        do_reset();
        repeat (2) do_vote(3'b001);
        repeat (2) do_vote(3'b010);
        close_poll();
        check("tie_tallies", 64'({tally_1, tally_2, tally_3}), 64'd0);
        check("tie_flags", 64'({winner, tie, audit_mismatch, tally_valid}), 64'b00_1_0_1);

        // Corrupted readback of candidate 2 must be flagged
        do_reset();
        corrupt = 1'b1;
        do_vote(3'b001);
        close_poll();
        check("audit_tallies", 64'({tally_1, tally_2, tally_3}), 64'({7'd1, 7'd1, 7'd0}));
        check("audit_flag", 64'(audit_mismatch), 64'd1);
        corrupt = 1'b0;

        // close_session while the voter deliberates
        begin
            int sd_early = 0;
            int k = 0;
            do_reset();
            clear_mon();
            pulse_enable();
            wait_for(0, 1'b1, 10, "cwb_busy_rise");
            @(negedge clk);
            close_session = 1'b1;
            @(negedge clk);
            close_session = 1'b0;
            button = 3'b010;
            repeat (6) begin
                @(negedge clk);
                if (voting_session_done) sd_early++;
            end
            button = 3'b000;
            while (busy && k < 40) begin
                @(negedge clk);
                if (voting_session_done) sd_early++;
                k++;
            end
            check("cwb_busy_fall", 64'(busy), 64'd0);
            check("cwb_early_done", 64'(sd_early), 64'd0);
            check("cwb_vote", 64'(vc_mask), 64'b010);
            wait_for(2, 1'b1, 5, "cwb_session_done");
            wait_for(1, 1'b1, 20, "cwb_tally_valid");
            check("cwb_tally_2", 64'(tally_2), 64'd1);
        end

        // EVM never answers: fault exactly 16 cycles after WAIT_VIP entry
        do_reset();
        mute = 1'b1;
        pulse_enable();
        wait_for(0, 1'b1, 10, "to_busy_rise");
        repeat (15) @(negedge clk);
        check("to_fault_early", 64'(fault), 64'd0);
        @(negedge clk);
        check("to_fault", 64'(fault), 64'd1);
        check("to_drives", 64'({busy, candidate_ready, voting_session_done}), 64'd0);
        pulse_enable();
        repeat (3) @(negedge clk);
        check("to_sticky", 64'({fault, candidate_ready}), 64'b10);
        mute = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
